// File: rtl/bp_me_stream_block_collector_pkg.sv
// Shared BedRock stream types and the beat-count helper used by collector and pump blocks.
package bp_me_stream_block_collector_pkg;

  localparam int bedrock_msg_type_width_gp = 4;
  localparam int bedrock_subop_width_gp    = 4;
  localparam int bedrock_msg_size_width_gp = 3;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  // Size field encodes log2 of the message size in bytes.
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef enum logic [1:0] {
    e_ready   = 2'd0,
    e_collect = 2'd1,
    e_send    = 2'd2
  } bp_me_collector_state_e;

  // log2 of the beat count of a message: data-carrying types span size/beat
  // beats (at least one); everything else is one beat. Saturates at max_beats_lg.
  function automatic logic [7:0] bp_me_stream_beats_lg(
    input logic [2:0]  size,
    input logic [3:0]  msg_type,
    input int unsigned stream_mask,
    input int          in_bytes_lg,
    input int          max_beats_lg
  );
    int beats_lg;
    beats_lg = 0;
    if (stream_mask[msg_type] && (int'(size) > in_bytes_lg))
      beats_lg = int'(size) - in_bytes_lg;
    if (beats_lg > max_beats_lg)
      beats_lg = max_beats_lg;
    return 8'(beats_lg);
  endfunction

endpackage

// File: rtl/bp_me_stream_block_collector_buffer.sv
// Slot-addressed block buffer with a replicate-on-read output mux.
module bp_me_stream_block_collector_buffer
  #(parameter int in_data_width_p  = 64
    , parameter int out_data_width_p = 512
    , localparam int slots_lp     = out_data_width_p / in_data_width_p
    , localparam int slot_w_lp    = ($clog2(slots_lp) > 0) ? $clog2(slots_lp) : 1
    , localparam int out_bytes_lp = out_data_width_p / 8
    , localparam int idx_w_lp     = $clog2(out_bytes_lp)
    )
  (input  logic                        clk_i
   , input  logic                        reset_i
   , input  logic                        w_v_i
   , input  logic [slot_w_lp-1:0]        w_slot_i
   , input  logic [in_data_width_p-1:0]  w_data_i
   , input  logic [7:0]                  gran_lg_i
   , output logic [out_data_width_p-1:0] data_o
   );

  localparam int in_bytes_lp = in_data_width_p / 8;

  logic [in_data_width_p-1:0] slot_q [slots_lp];
  logic [slots_lp-1:0]        slot_we;
  logic [7:0]                 flat_bytes [out_bytes_lp];
  logic [idx_w_lp-1:0]        gran_mask;

  // One write enable per slot, decoded from the write slot index.
  for (genvar gi = 0; gi < slots_lp; gi++) begin : g_we
    assign slot_we[gi] = w_v_i && (w_slot_i == slot_w_lp'(gi));
  end

  // Slot storage; cleared on reset so no stale block survives a reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < slots_lp; i++) begin
      if (reset_i)
        slot_q[i] <= '0;
      else if (slot_we[i])
        slot_q[i] <= w_data_i;
    end
  end

  // Byte view of the buffer in address order.
  for (genvar gi = 0; gi < out_bytes_lp; gi++) begin : g_flat
    assign flat_bytes[gi] = slot_q[gi / in_bytes_lp][8*(gi % in_bytes_lp) +: 8];
  end

  // Low-ones mask of width gran_lg: output byte i reads buffer byte i mod 2^gran_lg.
  always_comb begin
    gran_mask = '0;
    for (int i = 0; i < idx_w_lp; i++)
      gran_mask[i] = (gran_lg_i > 8'(i));
  end

  for (genvar gi = 0; gi < out_bytes_lp; gi++) begin : g_rep
    assign data_o[8*gi +: 8] = flat_bytes[idx_w_lp'(gi) & gran_mask];
  end

endmodule

// File: rtl/bp_me_stream_block_collector.sv
// Collects a multi-beat BedRock stream message into a single block-wide message.
// Header layout (LSB first): msg_type[4], subop[4], addr[paddr], size[3], payload.
module bp_me_stream_block_collector
  import bp_me_stream_block_collector_pkg::*;
  #(parameter int paddr_width_p = 40
    , parameter int in_data_width_p = 64
    , parameter int out_data_width_p = 512
    , parameter int payload_width_p = 16
    , parameter int unsigned stream_mask_p = (1 << e_bedrock_mem_wr) | (1 << e_bedrock_mem_uc_wr)
    , localparam int header_width_lp = payload_width_p + bedrock_msg_size_width_gp
                                       + paddr_width_p + bedrock_subop_width_gp
                                       + bedrock_msg_type_width_gp
    )
  (input  logic                        clk_i
   , input  logic                        reset_i
   , input  logic [header_width_lp-1:0]  in_msg_header_i
   , input  logic [in_data_width_p-1:0]  in_msg_data_i
   , input  logic                        in_msg_v_i
   , output logic                        in_msg_ready_and_o
   , output logic [header_width_lp-1:0]  out_msg_header_o
   , output logic [out_data_width_p-1:0] out_msg_data_o
   , output logic                        out_msg_v_o
   , input  logic                        out_msg_ready_and_i
   );

  localparam int in_bytes_lg_lp  = $clog2(in_data_width_p / 8);
  localparam int out_bytes_lg_lp = $clog2(out_data_width_p / 8);
  localparam int slots_lp        = out_data_width_p / in_data_width_p;
  localparam int max_beats_lg_lp = $clog2(slots_lp);
  localparam int slot_w_lp       = (max_beats_lg_lp > 0) ? max_beats_lg_lp : 1;
  localparam int addr_off_lp     = bedrock_msg_type_width_gp + bedrock_subop_width_gp;
  localparam int size_off_lp     = addr_off_lp + paddr_width_p;

  bp_me_collector_state_e     state_q, state_d;
  logic [slot_w_lp:0]         cnt_q, cnt_d;
  logic [slot_w_lp-1:0]       base_q, base_d;
  logic [slot_w_lp-1:0]       n_mask_q, n_mask_d;
  logic [7:0]                 gran_lg_q, gran_lg_d;
  logic [header_width_lp-1:0] header_q, header_d;
  logic                       v_q, v_d;

  logic [3:0]                 in_type;
  logic [2:0]                 in_size;
  logic [out_bytes_lg_lp-1:0] in_blk_off;
  logic [7:0]                 in_beats_lg;
  logic [slot_w_lp-1:0]       in_n_mask;
  logic [slot_w_lp-1:0]       in_base;
  int                         gran_int;
  logic                       in_accept;
  logic                       out_accept;
  logic                       wr_v;
  logic [slot_w_lp-1:0]       wr_slot;

  // Decode the incoming header: beat count, first slot and replication granule.
  always_comb begin
    in_type     = in_msg_header_i[0 +: bedrock_msg_type_width_gp];
    in_size     = in_msg_header_i[size_off_lp +: bedrock_msg_size_width_gp];
    in_blk_off  = in_msg_header_i[addr_off_lp +: out_bytes_lg_lp];
    in_beats_lg = bp_me_stream_beats_lg(in_size, in_type, stream_mask_p,
                                        in_bytes_lg_lp, max_beats_lg_lp);
    in_n_mask   = slot_w_lp'((32'd1 << in_beats_lg) - 32'd1);
    // Critical-word-first: the first beat belongs at the addressed beat within the N-beat window.
    in_base     = slot_w_lp'(in_blk_off >> in_bytes_lg_lp) & in_n_mask;
    // Replicate at the message size, but never wider than the data actually collected.
    gran_int    = int'(in_size);
    if (gran_int > int'(in_beats_lg) + in_bytes_lg_lp)
      gran_int = int'(in_beats_lg) + in_bytes_lg_lp;
    if (gran_int > out_bytes_lg_lp)
      gran_int = out_bytes_lg_lp;
  end

  assign in_msg_ready_and_o = (state_q != e_send);

  // Next-state logic for the ready/collect/send sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    n_mask_d   = n_mask_q;
    gran_lg_d  = gran_lg_q;
    header_d   = header_q;
    v_d        = v_q;
    wr_v       = 1'b0;
    wr_slot    = '0;
    in_accept  = in_msg_v_i & in_msg_ready_and_o;
    out_accept = v_q & out_msg_ready_and_i;
    case (state_q)
      e_ready: begin
        if (in_accept) begin
          header_d  = in_msg_header_i;
          base_d    = in_base;
          n_mask_d  = in_n_mask;
          gran_lg_d = 8'(gran_int);
          wr_v      = 1'b1;
          wr_slot   = in_base;
          cnt_d     = (slot_w_lp+1)'(1);
          if (in_n_mask == '0) begin
            state_d = e_send;
            v_d     = 1'b1;
          end else begin
            state_d = e_collect;
          end
        end
      end
      e_collect: begin
        if (in_accept) begin
          wr_v    = 1'b1;
          wr_slot = (base_q + cnt_q[slot_w_lp-1:0]) & n_mask_q;
          cnt_d   = cnt_q + (slot_w_lp+1)'(1);
          if (cnt_q == {1'b0, n_mask_q}) begin
            state_d = e_send;
            v_d     = 1'b1;
          end
        end
      end
      e_send: begin
        // Input is held off for this cycle even on handshake; the bubble is deliberate.
        if (out_accept) begin
          v_d     = 1'b0;
          cnt_d   = '0;
          state_d = e_ready;
        end
      end
      default: state_d = e_ready;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_ready;
      cnt_q     <= '0;
      base_q    <= '0;
      n_mask_q  <= '0;
      gran_lg_q <= '0;
      header_q  <= '0;
      v_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      n_mask_q  <= n_mask_d;
      gran_lg_q <= gran_lg_d;
      header_q  <= header_d;
      v_q       <= v_d;
    end
  end

  bp_me_stream_block_collector_buffer
    #(.in_data_width_p(in_data_width_p)
      ,.out_data_width_p(out_data_width_p)
      )
    buffer
     (.clk_i(clk_i)
      ,.reset_i(reset_i)
      ,.w_v_i(wr_v)
      ,.w_slot_i(wr_slot)
      ,.w_data_i(in_msg_data_i)
      ,.gran_lg_i(gran_lg_q)
      ,.data_o(out_msg_data_o)
      );

  assign out_msg_header_o = header_q;
  assign out_msg_v_o      = v_q;

endmodule

// File: tb/tb_bp_me_stream_block_collector.sv
// Directed plus randomized bench for the stream block collector with a byte-level reference model.
module tb_bp_me_stream_block_collector;
  import bp_me_stream_block_collector_pkg::*;

  localparam int PADDR = 40;
  localparam int INW   = 64;
  localparam int OUTW  = 512;
  localparam int PAYW  = 16;
  localparam int unsigned MASK = (1 << e_bedrock_mem_rd) | (1 << e_bedrock_mem_wr)
                               | (1 << e_bedrock_mem_uc_wr);
  localparam int HW    = PAYW + 3 + PADDR + 8;
  localparam int INB   = INW / 8;
  localparam int OUTB  = OUTW / 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [HW-1:0]   in_hdr;
  logic [INW-1:0]  in_data;
  logic            in_v;
  logic            in_ready;
  logic [HW-1:0]   out_hdr;
  logic [OUTW-1:0] out_data;
  logic            out_v;
  logic            out_ready;

  int checks = 0;
  int passes = 0;

  logic [INW-1:0]  beats [8];
  logic [OUTW-1:0] fixed_exp;
  bit              use_fixed = 1'b0;

  always #5 clk = ~clk;

  bp_me_stream_block_collector
    #(.paddr_width_p(PADDR), .in_data_width_p(INW), .out_data_width_p(OUTW),
      .payload_width_p(PAYW), .stream_mask_p(MASK))
    dut
     (.clk_i(clk), .reset_i(reset),
      .in_msg_header_i(in_hdr), .in_msg_data_i(in_data), .in_msg_v_i(in_v),
      .in_msg_ready_and_o(in_ready),
      .out_msg_header_o(out_hdr), .out_msg_data_o(out_data), .out_msg_v_o(out_v),
      .out_msg_ready_and_i(out_ready));

  task automatic chk(input string tag, input logic [OUTW-1:0] obs, input logic [OUTW-1:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] mt, input logic [PADDR-1:0] addr,
                                           input logic [2:0] size, input logic [PAYW-1:0] pay);
    return {pay, size, addr, 4'h0, mt};
  endfunction

  // Beats per message: data-carrying types need size/beat beats (min 1, max one block).
  function automatic int model_beats(input logic [3:0] mt, input logic [2:0] size);
    int n;
    n = 1;
    if (((MASK >> mt) & 1) != 0) begin
      n = (1 << size) / INB;
      if (n < 1) n = 1;
      if (n > OUTW / INW) n = OUTW / INW;
    end
    return n;
  endfunction

  // Place beat k at address-ordered slot (first_slot + k) mod N, then replicate
  // the lowest min(size, N beats, block) bytes across the block.
  function automatic logic [OUTW-1:0] model_block(input logic [3:0] mt, input logic [PADDR-1:0] addr,
                                                  input logic [2:0] size);
    logic [7:0]      blk [OUTB];
    logic [OUTW-1:0] res;
    int n, base, gran, slot;
    n    = model_beats(mt, size);
    base = int'(addr % OUTB) / INB;
    for (int i = 0; i < OUTB; i++) blk[i] = 8'h00;
    for (int k = 0; k < n; k++) begin
      slot = (base + k) % n;
      for (int b = 0; b < INB; b++) blk[slot*INB + b] = beats[k][8*b +: 8];
    end
    gran = 1 << size;
    if (gran > n * INB) gran = n * INB;
    if (gran > OUTB) gran = OUTB;
    res = '0;
    for (int i = 0; i < OUTB; i++) res[8*i +: 8] = blk[i % gran];
    return res;
  endfunction

  // Drive one whole message, check the assembled output, hold it for bp cycles, then hand it off.
  task automatic run_msg(input logic [3:0] mt, input logic [PADDR-1:0] addr, input logic [2:0] size,
                         input int bp, input bit gaps, input string name);
    logic [HW-1:0]   hdr;
    logic [OUTW-1:0] exp;
    int n;
    hdr = mk_hdr(mt, addr, size, PAYW'($urandom));
    n   = model_beats(mt, size);
    exp = use_fixed ? fixed_exp : model_block(mt, addr, size);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_v = 1'b0;
          in_data = {$urandom, $urandom};
          @(negedge clk);
          chk({name, "_gap_v"}, out_v, 1'b0);
        end
      end
      in_hdr  = hdr;
      in_data = beats[k];
      in_v    = 1'b1;
      chk({name, "_in_ready"}, in_ready, 1'b1);
      chk({name, "_v_early"}, out_v, 1'b0);
      @(negedge clk);
    end
    in_v    = 1'b0;
    in_data = {$urandom, $urandom};
    chk({name, "_v"}, out_v, 1'b1);
    chk({name, "_hdr"}, out_hdr, hdr);
    chk({name, "_data"}, out_data, exp);
    chk({name, "_in_ready_send"}, in_ready, 1'b0);
    for (int c = 0; c < bp; c++) begin
      in_v    = 1'b1;
      in_data = {$urandom, $urandom};
      in_hdr  = mk_hdr(4'($urandom_range(0, 3)), {$urandom, $urandom}, 3'($urandom), PAYW'($urandom));
      @(negedge clk);
      chk({name, "_bp_v"}, out_v, 1'b1);
      chk({name, "_bp_hdr"}, out_hdr, hdr);
      chk({name, "_bp_data"}, out_data, exp);
      chk({name, "_bp_in_ready"}, in_ready, 1'b0);
    end
    in_v      = 1'b1;
    in_data   = {$urandom, $urandom};
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_v      = 1'b0;
    chk({name, "_done_v"}, out_v, 1'b0);
    chk({name, "_done_in_ready"}, in_ready, 1'b1);
    $display("msg %s type=%0d addr=%0h size=%0d beats=%0d bp=%0d checks=%0d passed=%0d",
             name, mt, addr, size, n, bp, checks, passes);
  endtask

  initial begin
    reset = 1'b1; in_v = 1'b0; out_ready = 1'b0; in_hdr = '0; in_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_v", out_v, 1'b0);
    chk("reset_hdr", out_hdr, '0);
    chk("reset_data", out_data, '0);
    chk("reset_in_ready", in_ready, 1'b1);

    // Full-block write, beats 0..7 in order.
    for (int k = 0; k < 8; k++) beats[k] = 64'(k);
    run_msg(e_bedrock_mem_wr, 40'h1000, e_bedrock_msg_size_64, 0, 1'b0, "full_wr");

    // Critical-word-first read response starting at beat 3.
    for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
    run_msg(e_bedrock_mem_rd, 40'h1018, e_bedrock_msg_size_64, 0, 1'b0, "cwf_rd");

    // Sub-beat write replicated across the block.
    beats[0]  = 64'h0000_0000_DEAD_BEEF;
    fixed_exp = {16{32'hDEADBEEF}};
    use_fixed = 1'b1;
    run_msg(e_bedrock_mem_wr, 40'h2004, e_bedrock_msg_size_4, 0, 1'b0, "sub_beat");
    use_fixed = 1'b0;

    // Non-stream type completes on a single beat.
    beats[0] = {$urandom, $urandom};
    run_msg(e_bedrock_mem_uc_rd, 40'h3000, e_bedrock_msg_size_64, 0, 1'b0, "uc_rd");

    // Backpressure, then the next message starts right after the handshake.
    for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
    run_msg(e_bedrock_mem_wr, 40'h4020, e_bedrock_msg_size_64, 5, 1'b0, "bp");
    for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
    run_msg(e_bedrock_mem_uc_wr, 40'h4100, e_bedrock_msg_size_32, 0, 1'b0, "after_bp");

    // Reset after three of eight beats discards the partial message.
    in_hdr = mk_hdr(e_bedrock_mem_wr, 40'h5000, e_bedrock_msg_size_64, 16'h1234);
    for (int k = 0; k < 3; k++) begin
      in_data = {$urandom, $urandom};
      in_v    = 1'b1;
      @(negedge clk);
    end
    in_v  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_v", out_v, 1'b0);
    chk("midreset_hdr", out_hdr, '0);
    chk("midreset_data", out_data, '0);
    chk("midreset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("midreset_v_hold", out_v, 1'b0);
    for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
    run_msg(e_bedrock_mem_wr, 40'h5010, e_bedrock_msg_size_64, 0, 1'b0, "post_reset");

    // Randomized messages against the reference model.
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
      run_msg(4'($urandom_range(0, 3)), PADDR'({$urandom, $urandom}), 3'($urandom_range(0, 7)),
              $urandom_range(0, 3), 1'b1, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
